// File: rtl/frame_pkg.sv
// Shared definitions for the frame segmenter: metadata field offsets,
// beat geometry helpers and the frame-state encoding.
package frame_pkg;

  localparam int MD_COUNT_LSB = 0;
  localparam int MD_SEQ_LSB   = 32;
  localparam int MD_SHORT_BIT = 64;

  typedef enum logic {
    S_START = 1'b0,
    S_BODY  = 1'b1
  } state_t;

  function automatic int bpb_of(input int dw);
    return dw / 8;
  endfunction

  function automatic int log2_of(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keep_popcount.sv
// Counts the set bits of a TKEEP vector, i.e. the bytes carried by one beat.
module keep_popcount #(
  parameter int BPB = 64
) (
  input  logic [BPB-1:0]         keep,
  output logic [$clog2(BPB):0]   count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < BPB; i++) begin
      count = count + {{$clog2(BPB){1'b0}}, keep[i]};
    end
  end

endmodule

// File: rtl/frame_segmenter.sv
// Cuts an AXI-Stream into FRAME_SIZE-byte frames and emits one metadata beat
// (byte count, sequence number, short flag) per completed frame.
module frame_segmenter
  import frame_pkg::*;
#(
  parameter int DW = 512
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [31:0]            FRAME_SIZE,
  input  logic [DW-1:0]          AXIS_IN_TDATA,
  input  logic                   AXIS_IN_TVALID,
  input  logic [DW/8-1:0]        AXIS_IN_TKEEP,
  input  logic                   AXIS_IN_TLAST,
  output logic                   AXIS_IN_TREADY,
  output logic [DW-1:0]          AXIS_OUT_TDATA,
  output logic                   AXIS_OUT_TVALID,
  output logic [DW/8-1:0]        AXIS_OUT_TKEEP,
  output logic                   AXIS_OUT_TLAST,
  input  logic                   AXIS_OUT_TREADY,
  output logic [DW-1:0]          AXIS_OUT_MD_TDATA,
  output logic                   AXIS_OUT_MD_TVALID,
  output logic                   AXIS_OUT_MD_TLAST,
  input  logic                   AXIS_OUT_MD_TREADY,
  output logic                   state_dbg
);

  localparam int BPB = bpb_of(DW);
  localparam int LB  = log2_of(BPB);

  // Handshake: a beat moves when VALID and READY are both high at a rising
  // edge; VALID never depends on READY and payloads hold while VALID waits.

  state_t          state, state_next;
  logic [32:0]     nb_q, beat_cnt, nb_now, nb_cur, cur_cnt;
  logic [BPB-1:0]  mask_q, mask_now, mask_cur, keep_out;
  logic [31:0]     byte_acc, seq, es, residue, frame_bytes;
  logic [DW-1:0]   data_out, md_word;
  logic [LB:0]     beat_bytes;
  logic            accept, full_end, frame_end;

  assign AXIS_IN_TREADY = !reset && (!AXIS_OUT_TVALID || AXIS_OUT_TREADY) &&
                          !(AXIS_OUT_MD_TVALID && !AXIS_OUT_MD_TREADY);
  assign accept    = AXIS_IN_TVALID && AXIS_IN_TREADY;
  assign AXIS_OUT_MD_TLAST = AXIS_OUT_MD_TVALID;
  assign state_dbg = state;

  // Frame geometry from the current FRAME_SIZE; only used on a frame's first beat.
  always_comb begin
    es       = (FRAME_SIZE == 32'd0) ? 32'(BPB) : FRAME_SIZE;
    residue  = es & 32'(BPB - 1);
    nb_now   = ({1'b0, es} + 33'(BPB - 1)) >> LB;
    mask_now = '0;
    for (int i = 0; i < BPB; i++) begin
      mask_now[i] = (residue == 32'd0) || (32'(i) < residue);
    end
  end

  assign nb_cur    = (state == S_START) ? nb_now : nb_q;
  assign mask_cur  = (state == S_START) ? mask_now : mask_q;
  assign cur_cnt   = (state == S_START) ? 33'd1 : beat_cnt + 33'd1;
  assign full_end  = (cur_cnt == nb_cur);
  assign frame_end = full_end || AXIS_IN_TLAST;

  // Bytes past the residue on a full frame's last beat are dropped entirely.
  always_comb begin
    keep_out = full_end ? (AXIS_IN_TKEEP & mask_cur) : AXIS_IN_TKEEP;
    data_out = AXIS_IN_TDATA;
    for (int i = 0; i < BPB; i++) begin
      if (full_end && !mask_cur[i]) data_out[8*i +: 8] = 8'h00;
    end
  end

  keep_popcount #(.BPB(BPB)) u_pop (
    .keep  (keep_out),
    .count (beat_bytes)
  );

  assign frame_bytes = byte_acc + 32'(beat_bytes);

  always_comb begin
    md_word = '0;
    md_word[MD_COUNT_LSB +: 32] = frame_bytes;
    md_word[MD_SEQ_LSB +: 32]   = seq;
    md_word[MD_SHORT_BIT]       = !full_end;
  end

  always_comb begin
    state_next = state;
    if (accept) state_next = frame_end ? S_START : S_BODY;
  end

  always_ff @(posedge clk) begin
    if (reset) state <= S_START;
    else       state <= state_next;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      nb_q               <= '0;
      mask_q             <= '0;
      beat_cnt           <= '0;
      byte_acc           <= '0;
      seq                <= '0;
      AXIS_OUT_TVALID    <= 1'b0;
      AXIS_OUT_TDATA     <= '0;
      AXIS_OUT_TKEEP     <= '0;
      AXIS_OUT_TLAST     <= 1'b0;
      AXIS_OUT_MD_TVALID <= 1'b0;
      AXIS_OUT_MD_TDATA  <= '0;
    end else begin
      if (accept) begin
        if (state == S_START) begin
          nb_q   <= nb_now;
          mask_q <= mask_now;
        end
        if (frame_end) begin
          beat_cnt <= '0;
          byte_acc <= '0;
          seq      <= seq + 32'd1;
        end else begin
          beat_cnt <= cur_cnt;
          byte_acc <= frame_bytes;
        end
        AXIS_OUT_TVALID <= 1'b1;
        AXIS_OUT_TDATA  <= data_out;
        AXIS_OUT_TKEEP  <= keep_out;
        AXIS_OUT_TLAST  <= frame_end;
      end else if (AXIS_OUT_TREADY) begin
        AXIS_OUT_TVALID <= 1'b0;
      end
      // A drain and a new frame end in the same cycle reload with no bubble.
      if (AXIS_OUT_MD_TVALID && AXIS_OUT_MD_TREADY) AXIS_OUT_MD_TVALID <= 1'b0;
      if (accept && frame_end) begin
        AXIS_OUT_MD_TVALID <= 1'b1;
        AXIS_OUT_MD_TDATA  <= md_word;
      end
    end
  end

endmodule

// File: doc/frame_segmenter.md
# frame_segmenter

Upstream feeder for the frame header adder. Cuts an incoming AXI-Stream into frames of FRAME_SIZE bytes, drives TLAST on each frame's final beat, and masks that beat's TKEEP to the frame's byte residue. For every completed frame it emits one metadata beat carrying byte count, sequence number and a short-frame flag. The data and metadata outputs connect directly to the header adder's AXIS_IN_* and AXIS_IN_MD_* ports.

## Interface
- DW, 512, data width in bits; power of two, at least 64. BPB = DW/8 bytes per beat.
- clk  in  1  sole clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- FRAME_SIZE  in  32  frame size in bytes; sampled on the first beat of each frame.
- AXIS_IN_TDATA / TVALID / TKEEP / TLAST  in  DW / 1 / BPB / 1  source stream; TLAST forces an early frame end.
- AXIS_IN_TREADY  out  1  source backpressure.
- AXIS_OUT_TDATA / TVALID / TKEEP / TLAST  out  DW / 1 / BPB / 1  framed stream.
- AXIS_OUT_TREADY  in  1  sink ready.
- AXIS_OUT_MD_TDATA  out  DW  metadata: [31:0] byte count, [63:32] sequence number, [64] short flag, all other bits 0.
- AXIS_OUT_MD_TVALID / AXIS_OUT_MD_TLAST  out  1 / 1  metadata valid; TLAST is 1 whenever TVALID is 1.
- AXIS_OUT_MD_TREADY  in  1  metadata sink ready.

## Operation
- Effective size: ES = BPB if FRAME_SIZE == 0, otherwise FRAME_SIZE.
- Beats per frame: NB = ceil(ES/BPB). Compute in 33 bits, then shift right by log2(BPB).
- Residue: R = ES mod BPB. Final-beat mask: low R bits set if R != 0, otherwise all ones.
- States:
  - S_START: the next accepted beat latches NB and the mask.
  - S_BODY: beats counted until the frame ends.
- Frame end:
  - Full frame: beat count reaches NB. Output TKEEP = input TKEEP & mask. Input bytes above the residue are discarded.
  - Early frame: input TLAST arrives before NB beats. The beat passes with input TKEEP unchanged and short=1.
  - A beat that is both the NB-th beat and TLAST counts as a full frame (short=0, mask applied).
  - After either end, return to S_START.
- Byte count: 32-bit sum of popcount(output TKEEP) over the frame's beats.
- Metadata: written into a one-entry register in the same cycle the frame's last beat enters the output register. Sequence number then increments, wrapping from 0xFFFFFFFF to 0.
- Accept rule: AXIS_IN_TREADY = (!AXIS_OUT_TVALID | AXIS_OUT_TREADY) & !(AXIS_OUT_MD_TVALID & !AXIS_OUT_MD_TREADY). When the metadata register is full and not draining, all intake stalls.
- Reset, including mid-frame: the partial frame is dropped; state S_START; counters, sequence number and metadata register cleared.

## Timing
- Data latency: 1 cycle, input accept to AXIS_OUT_TVALID, through a single registered stage.
- Full throughput: one beat per cycle while the sink is ready and metadata drains.
- Metadata TVALID rises the cycle after the last beat is accepted, i.e. together with the data beat carrying TLAST. It is never later than that beat.
- Output TDATA/TKEEP/TLAST stay stable while TVALID=1 and TREADY=0; the same holds for metadata.
- Reset values: AXIS_IN_TREADY=0 during reset, both TVALIDs=0, TLAST=0, MD_TLAST=0, TKEEP=0, TDATA=0, MD_TDATA=0.
- Simultaneous metadata drain and new frame end in one cycle is allowed; the register reloads with no bubble.
- FRAME_SIZE changes mid-frame take effect at the next S_START.

## Structure
- Package frame_pkg holds:
  - MD field offsets (MD_COUNT_LSB=0, MD_SEQ_LSB=32, MD_SHORT_BIT=64).
  - BPB and log2(BPB) helper functions.
  - State enum S_START/S_BODY.
- Sub-module keep_popcount (parameter BPB): combinational popcount of the masked TKEEP, output width log2(BPB)+1.

## Test plan
- DW=512, FRAME_SIZE=128, 6 full beats, sinks always ready:
  - TLAST on beats 2, 4, 6.
  - Metadata count=128 with seq 0, 1, 2; short=0.
- FRAME_SIZE=100, 4 beats:
  - Beats 2 and 4 have TKEEP=0x0000000FFFFFFFFF.
  - Metadata count=100 twice.
- FRAME_SIZE=256, input TLAST on beat 2 with TKEEP=0xFFFF, then 4 beats:
  - Frame 0: count=80, short=1.
  - Frame 1: count=256, short=0, seq=1.
- AXIS_OUT_MD_TREADY held 0 across two frame ends (FRAME_SIZE=64):
  - AXIS_IN_TREADY drops after the first frame's beat.
  - No metadata or data lost.
  - Release, then verify seq 0, 1 in order.
- Random AXIS_OUT_TREADY toggling at 50%:
  - Output matches the reference model.
  - Held beats stay stable.
- Assert reset mid-frame (beat 1 of 2), then resume:
  - All outputs return to reset values the next cycle.
  - First new metadata has seq=0 and a full count.
